parallel2serial: RTL and testbench
==================================

# parallel2serial

Host-to-keyboard PS/2 transmitter: accepts a byte from the system side and sends it to the keyboard using the PS/2 host-to-device protocol (inhibit, request-to-send, 8 data bits LSB first, odd parity, stop, device ACK). It is the transmit counterpart of `serial2parallel` and shares the same keyboard clock and data lines. Lines are open-drain; this block only outputs pull-low enables. It runs entirely in the system clock domain and senses the keyboard lines through internal synchronizers.

## Interface
- `INHIBIT_CYCLES`, 5000: system cycles the keyboard clock is held low before request-to-send (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, 750000: maximum system cycles from clock release to completion (15 ms at 50 MHz).

- `Clock` in 1: system clock; all logic on its rising edge.
- `iReset` in 1: asynchronous, active-high reset.
- `iStart` in 1: request to send `i8b`; accepted only when `oBusy`=0.
- `i8b` in 8: byte to send; latched on the accepting cycle.
- `iClockTeclado` in 1: sensed level of the keyboard clock line (asynchronous).
- `i1b` in 1: sensed level of the keyboard data line (asynchronous).
- `oClockLow` out 1: 1 = pull the keyboard clock line low.
- `oDataLow` out 1: 1 = pull the keyboard data line low.
- `oBusy` out 1: transfer in progress.
- `oDone` out 1: one-cycle pulse at the end of every accepted transfer.
- `oError` out 1: valid with `oDone`. 1 = NACK or timeout.

## Operation
- Synchronizers: two flops each on `iClockTeclado` and `i1b`. A falling edge is a synchronized 1→0 on the clock, detected with one more register.
- Shift data: `{stop=1, parity, i8b[7:0]}`. Parity = `~^i8b`, which gives an odd count of ones over data plus parity.
- Edge counter runs 0..11.
- States and transitions:
  - IDLE: lines released. `iStart` → INHIBIT, latches the byte, clears counters.
  - INHIBIT: `oClockLow`=1 for exactly `INHIBIT_CYCLES` cycles → RTS.
  - RTS: one cycle with `oClockLow`=1 and `oDataLow`=1 (start bit) → XFER. The timeout counter starts here.
  - XFER: `oClockLow`=0. On falling edge n (n=1..10), `oDataLow` = ~bit(n-1), where bit 0..7 = data, bit 8 = parity, bit 9 = stop (line released). On falling edge 11, sample synchronized data: 0 = ACK, 1 = NACK (error flag set) → WAITIDLE.
  - WAITIDLE: wait until synchronized clock and data are both 1 → IDLE, pulsing `oDone` (and `oError` if the flag is set).
- Timeout: if the counter reaches `TIMEOUT_CYCLES` in XFER or WAITIDLE, release both lines, pulse `oDone`=1 and `oError`=1, and return to IDLE.
- `iStart` while busy: ignored. Changes on `i8b` during a transfer have no effect.
- Reset, including mid-transfer: all outputs 0 immediately (lines released, `oBusy`=0, no `oDone` pulse), state IDLE.

## Timing
- Reset values: `oClockLow`=0, `oDataLow`=0, `oBusy`=0, `oDone`=0, `oError`=0.
- `oBusy` and `oClockLow` go to 1 the cycle after `iStart` is sampled. `oBusy` stays 1 through the cycle before the `oDone` pulse and is 0 during that pulse cycle.
- `oDataLow` rises `INHIBIT_CYCLES` cycles after `oClockLow` rises. `oClockLow` falls one cycle later.
- `oDataLow` updates 3 system cycles after a pad falling edge on the keyboard clock (2 synchronizer flops + 1 edge register). The keyboard samples on the following rising edge, half a PS/2 period later.
- `oDone` occurs 3–4 cycles after both lines are high following edge 11.
- A new `iStart` is accepted the cycle after `oDone`.
- All outputs are registered.

## Test plan
Bench settings: `INHIBIT_CYCLES`=8, `TIMEOUT_CYCLES`=2000, keyboard model clocking at a 40-cycle period after it sees the start bit.

- Send 0xED → `oClockLow` high for 8 cycles, then 1 RTS cycle. Model captures start 0, data bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Model ACKs → `oDone`=1, `oError`=0.
- Send 0x01 → parity bit 0. Send 0x00 → parity bit 1. Both complete with no error.
- Model leaves data high on clock 11 (NACK) → after lines idle, `oDone`=1 and `oError`=1.
- Model never clocks → `oDone`=`oError`=1 exactly 2000 cycles after RTS ends. Both lines released.
- Assert `iReset` after the 4th falling edge → `oClockLow`=`oDataLow`=`oBusy`=0 asynchronously and no `oDone`. A following send of 0xF4 completes normally.
- `iStart` pulsed with 0xAA during a 0xED transfer, and `i8b` changed mid-frame → the model still receives 0xED and no second transfer starts.

Source files
------------

// File: rtl/parallel2serial.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, then shifts a byte
// out on keyboard-generated clock edges and checks the device ACK.
`timescale 1ns/1ps

module parallel2serial #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       Clock,
  input  logic       iReset,
  input  logic       iStart,
  input  logic [7:0] i8b,
  input  logic       iClockTeclado,
  input  logic       i1b,
  output logic       oClockLow,
  output logic       oDataLow,
  output logic       oBusy,
  output logic       oDone,
  output logic       oError
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, XFER, WAITIDLE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       edge_q, edge_d;
  logic [9:0]       frame_q, frame_d;
  logic             err_flag_q, err_flag_d;
  logic             clock_low_q, clock_low_d;
  logic             data_low_q, data_low_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic clk_s1_q, clk_s2_q, clk_s3_q;
  logic dat_s1_q, dat_s2_q;
  logic clk_fall;

  // NOTE: synchronizers reset to 1 (idle bus level) so leaving reset never
  // looks like a keyboard clock falling edge.
  always_ff @(posedge Clock or posedge iReset) begin
    if (iReset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      clk_s3_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= iClockTeclado;
      clk_s2_q <= clk_s1_q;
      clk_s3_q <= clk_s2_q;
      dat_s1_q <= i1b;
      dat_s2_q <= dat_s1_q;
    end
  end

  assign clk_fall = clk_s3_q & ~clk_s2_q;

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_d     = edge_q;
    frame_d    = frame_q;
    err_flag_d = err_flag_q;
    data_low_d = data_low_q;
    done_d     = 1'b0;
    error_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        data_low_d = 1'b0;
        if (iStart) begin
          state_d    = INHIBIT;
          frame_d    = {1'b1, ~^i8b, i8b};
          cnt_d      = '0;
          edge_d     = '0;
          err_flag_d = 1'b0;
        end
      end
      INHIBIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == INH_LAST) begin
          state_d    = RTS;
          data_low_d = 1'b1;
        end
      end
      RTS: begin
        state_d = XFER;
        cnt_d   = '0;
      end
      XFER: begin
        cnt_d = cnt_q + 1'b1;
        if (clk_fall) begin
          edge_d = edge_q + 4'd1;
          if (edge_q == 4'd10) begin
            err_flag_d = dat_s2_q;
            data_low_d = 1'b0;
            state_d    = WAITIDLE;
          end else begin
            // Low end of the frame goes out first: data LSB..MSB, parity, stop.
            data_low_d = ~frame_q[0];
            frame_d    = {1'b0, frame_q[9:1]};
          end
        end
      end
      WAITIDLE: begin
        cnt_d      = cnt_q + 1'b1;
        data_low_d = 1'b0;
        if (clk_s2_q && dat_s2_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
          error_d = err_flag_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_q == XFER || state_q == WAITIDLE) && cnt_q == TMO_LAST) begin
      state_d    = IDLE;
      data_low_d = 1'b0;
      done_d     = 1'b1;
      error_d    = 1'b1;
    end

    clock_low_d = (state_d == INHIBIT) || (state_d == RTS);
    busy_d      = (state_d != IDLE);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge Clock or posedge iReset) begin
    if (iReset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      edge_q      <= '0;
      frame_q     <= '0;
      err_flag_q  <= 1'b0;
      clock_low_q <= 1'b0;
      data_low_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      edge_q      <= edge_d;
      frame_q     <= frame_d;
      err_flag_q  <= err_flag_d;
      clock_low_q <= clock_low_d;
      data_low_q  <= data_low_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign oClockLow = clock_low_q;
  assign oDataLow  = data_low_q;
  assign oBusy     = busy_q;
  assign oDone     = done_q;
  assign oError    = error_q;

endmodule

// File: tb/tb_parallel2serial.sv
// Randomized scoreboard bench for parallel2serial with a PS/2 keyboard model on
// open-drain clock/data lines.
`timescale 1ns/1ps

module tb_parallel2serial;

  localparam int INH  = 8;
  localparam int TMO  = 2000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] din;
  logic       kb_clk_line, kb_dat_line;
  logic       clock_low, data_low, busy, done, error;

  logic kb_clk_drv = 1'b1;
  logic kb_dat_drv = 1'b1;

  // Wired-AND of the open-drain lines: either side may pull low.
  assign kb_clk_line = kb_clk_drv & ~clock_low;
  assign kb_dat_line = kb_dat_drv & ~data_low;

  parallel2serial #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .Clock        (clk),
    .iReset       (rst),
    .iStart       (start),
    .i8b          (din),
    .iClockTeclado(kb_clk_line),
    .i1b          (kb_dat_line),
    .oClockLow    (clock_low),
    .oDataLow     (data_low),
    .oBusy        (busy),
    .oDone        (done),
    .oError       (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       err;
    logic       chk;
  } exp_t;

  exp_t exp_q[$];

  // Keyboard model state
  int         kb_mode = 0;   // 0 ACK, 1 NACK, 2 silent, 3 abort after edge 4
  logic       abort_pt = 1'b0;
  logic       rx_done = 1'b0;
  logic       rx_start, rx_par, rx_stop;
  logic [7:0] rx_data;
  int         idle_cyc = 0;

  task automatic kb_frame();
    logic [9:0] bits;
    bits    = '0;
    rx_done = 1'b0;
    if (kb_mode == 2) begin
      for (int i = 0; i < TMO + 100 && busy; i++) @(negedge clk);
      return;
    end
    repeat (HALF) @(negedge clk);
    rx_start = kb_dat_line;
    for (int n = 1; n <= 10; n++) begin
      kb_clk_drv = 1'b0;
      repeat (HALF) @(negedge clk);
      if (kb_mode == 3 && n == 4) begin
        abort_pt = 1'b1;
        repeat (20) @(negedge clk);
        kb_clk_drv = 1'b1;
        return;
      end
      kb_clk_drv = 1'b1;
      bits = {kb_dat_line, bits[9:1]};
      if (n < 10) repeat (HALF) @(negedge clk);
    end
    rx_data = bits[7:0];
    rx_par  = bits[8];
    rx_stop = bits[9];
    repeat (HALF / 2) @(negedge clk);
    if (kb_mode == 0) kb_dat_drv = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    kb_clk_drv = 1'b0;
    repeat (HALF) @(negedge clk);
    kb_clk_drv = 1'b1;
    rx_done    = 1'b1;
    if (kb_mode != 0) idle_cyc = cyc;
    repeat (5) @(negedge clk);
    kb_dat_drv = 1'b1;
    if (kb_mode == 0) idle_cyc = cyc;
  endtask

  initial begin : kb_model
    forever begin
      @(negedge clk);
      if (!rst && busy && !clock_low && data_low) kb_frame();
    end
  end

  // Monitor: every oDone pulse consumes one expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (error && !done) check("error_without_done", 32'(error), 32'(0));
      if (done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 32'(done), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("done_error", 32'(error), 32'(e.err));
          check("done_busy", 32'(busy), 32'(0));
          check("done_lines", 32'({clock_low, data_low}), 32'(0));
          if (e.chk) begin
            check("rx_complete", 32'(rx_done), 32'(1));
            check("rx_start", 32'(rx_start), 32'(0));
            check("rx_data", 32'(rx_data), 32'(e.data));
            check("rx_parity", 32'(rx_par), 32'(e.par));
            check("rx_stop", 32'(rx_stop), 32'(1));
            check("done_latency_ok", 32'((cyc - idle_cyc) >= 3 && (cyc - idle_cyc) <= 4), 32'(1));
          end
        end
      end
    end
  end

  task automatic start_xfer(input logic [7:0] b, input bit push, input bit err,
                            input bit chk, output int t_x);
    exp_t e;
    int   n_inh;
    int   n_rts;
    @(negedge clk);
    din   = b;
    start = 1'b1;
    if (push) begin
      e.data = b;
      e.par  = ($countones(b) % 2 == 0);
      e.err  = err;
      e.chk  = chk;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'(1));
    n_inh = 0;
    while (clock_low && !data_low && n_inh < 100) begin
      n_inh++;
      @(negedge clk);
    end
    check("inhibit_cycles", 32'(n_inh), 32'(INH));
    n_rts = 0;
    while (clock_low && data_low && n_rts < 100) begin
      n_rts++;
      @(negedge clk);
    end
    check("rts_cycles", 32'(n_rts), 32'(1));
    check("xfer_lines", 32'({clock_low, data_low}), 32'b01);
    t_x = cyc;
  endtask

  task automatic wait_done(output int t_d);
    int n;
    n   = 0;
    t_d = -1;
    while (n < TMO + 1000) begin
      @(negedge clk);
      n++;
      if (done) begin
        t_d = cyc;
        break;
      end
    end
    check("done_seen", 32'(done), 32'(1));
  endtask

  task automatic send(input logic [7:0] b, input int mode);
    int tx, td;
    kb_mode = mode;
    start_xfer(b, 1'b1, (mode != 0), 1'b1, tx);
    wait_done(td);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int         tx, td, n;
    logic [7:0] b;
    logic       nack;

    rst   = 1'b1;
    start = 1'b0;
    din   = 8'h00;
    #1;
    check("reset_clock_low", 32'(clock_low), 32'(0));
    check("reset_data_low", 32'(data_low), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_error", 32'(error), 32'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Directed frames: 0xED, then 0x01 and 0x00 back to back.
    send(8'hED, 0);
    repeat (10) @(negedge clk);
    send(8'h01, 0);
    send(8'h00, 0);
    repeat (10) @(negedge clk);

    // NACK
    send(8'h3C, 1);
    repeat (10) @(negedge clk);

    // Silent keyboard: timeout measured from the end of RTS.
    kb_mode = 2;
    start_xfer(8'h5A, 1'b1, 1'b1, 1'b0, tx);
    wait_done(td);
    check("timeout_latency", 32'(td - tx), 32'(TMO));
    repeat (10) @(negedge clk);

    // Reset after the 4th falling edge, no oDone expected.
    kb_mode = 3;
    start_xfer(8'h96, 1'b0, 1'b0, 1'b0, tx);
    n = 0;
    while (!abort_pt && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("abort_point_reached", 32'(abort_pt), 32'(1));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_clock_low", 32'(clock_low), 32'(0));
    check("async_rst_data_low", 32'(data_low), 32'(0));
    check("async_rst_busy", 32'(busy), 32'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    abort_pt = 1'b0;
    send(8'hF4, 0);
    repeat (10) @(negedge clk);

    // Start pulse and byte change while a 0xED frame is on the wire.
    kb_mode = 0;
    start_xfer(8'hED, 1'b1, 1'b0, 1'b1, tx);
    repeat (100) @(negedge clk);
    din   = 8'hAA;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    din = 8'h55;
    wait_done(td);
    repeat (20) @(negedge clk);
    check("no_second_xfer", 32'(busy), 32'(0));

    // Random bytes, occasionally NACKed.
    for (int i = 0; i < 6; i++) begin
      b    = 8'($urandom_range(0, 255));
      nack = ($urandom_range(0, 3) == 0);
      send(b, nack ? 1 : 0);
      repeat (10) @(negedge clk);
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
